// File: rtl/lii_mem_initiator_if.sv
// User-side and LII-side signal bundle for lii_mem_initiator.
// The slave modport is the initiator's view; master is the surrounding kernel/router.
interface lii_mem_initiator_if #(
    parameter int unsigned AXI_AW = 48,
    parameter int unsigned AXI_DW = 128,
    parameter int unsigned LII_DW = 256,
    parameter int unsigned TAG_W  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [AXI_AW-1:0]     cmd_addr;
    logic [7:0]            cmd_len;
    logic [2:0]            cmd_size;
    logic [TAG_W-1:0]      cmd_tag;

    logic [AXI_DW-1:0]     wr_data;
    logic [AXI_DW/8-1:0]   wr_strb;
    logic                  wr_valid;
    logic                  wr_ready;

    logic [AXI_DW-1:0]     rd_data;
    logic                  rd_last;
    logic                  rd_valid;
    logic                  rd_ready;

    logic                  wr_done_valid;
    logic                  wr_done_ready;
    logic [1:0]            wr_done_resp;

    logic [LII_DW-1:0]     lii_req_data;
    logic [LII_DW/8-1:0]   lii_req_keep;
    logic [LII_DW/8-1:0]   lii_req_strb;
    logic                  lii_req_last;
    logic                  lii_req_valid;
    logic                  lii_req_ready;

    logic [LII_DW-1:0]     lii_resp_data;
    logic [LII_DW/8-1:0]   lii_resp_keep;
    logic [LII_DW/8-1:0]   lii_resp_strb;
    logic                  lii_resp_last;
    logic                  lii_resp_valid;
    logic                  lii_resp_ready;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_size, cmd_tag,
        output cmd_ready,
        input  wr_data, wr_strb, wr_valid,
        output wr_ready,
        output rd_data, rd_last, rd_valid,
        input  rd_ready,
        output wr_done_valid, wr_done_resp,
        input  wr_done_ready,
        output lii_req_data, lii_req_keep, lii_req_strb, lii_req_last, lii_req_valid,
        input  lii_req_ready,
        input  lii_resp_data, lii_resp_keep, lii_resp_strb, lii_resp_last, lii_resp_valid,
        output lii_resp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_size, cmd_tag,
        input  cmd_ready,
        output wr_data, wr_strb, wr_valid,
        input  wr_ready,
        input  rd_data, rd_last, rd_valid,
        output rd_ready,
        input  wr_done_valid, wr_done_resp,
        output wr_done_ready,
        input  lii_req_data, lii_req_keep, lii_req_strb, lii_req_last, lii_req_valid,
        output lii_req_ready,
        output lii_resp_data, lii_resp_keep, lii_resp_strb, lii_resp_last, lii_resp_valid,
        input  lii_resp_ready
    );
endinterface

// File: rtl/lii_mem_initiator.sv
// LII memory initiator: packs one read/write command (plus write beats) into request flits
// and unpacks the response stream into read beats or a write-completion status.
module lii_mem_initiator #(
    parameter int unsigned AXI_AW = 48,
    parameter int unsigned AXI_DW = 128,
    parameter int unsigned LII_DW = 256,
    parameter int unsigned TAG_W  = 8
) (
    input  logic                clk,
    input  logic                rstn,
    lii_mem_initiator_if.slave  bus,
    output logic                busy,
    output logic                err_len
);
    localparam int unsigned SW = AXI_DW / 8;
    localparam int unsigned LB = LII_DW / 8;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSendHdr = 3'd1;
    localparam logic [2:0] StSendW   = 3'd2;
    localparam logic [2:0] StWaitR   = 3'd3;
    localparam logic [2:0] StWaitB   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              op_q, op_d;
    logic [7:0]        len_q, len_d;
    logic [8:0]        beat_rem_q, beat_rem_d;
    logic [8:0]        beat_cnt_q, beat_cnt_d;
    logic [LII_DW-1:0] req_data_q, req_data_d;
    logic [LB-1:0]     req_keep_q, req_keep_d;
    logic [LB-1:0]     req_strb_q, req_strb_d;
    logic              req_last_q, req_last_d;
    logic              req_valid_q, req_valid_d;
    logic              done_valid_q, done_valid_d;
    logic [1:0]        done_resp_q, done_resp_d;
    logic              err_q, err_d;
    logic [LII_DW-1:0] hdr;
    logic              wr_hs, resp_hs;
    logic              unused_resp;

    always_comb begin
        hdr = '0;
        hdr[LII_DW-1 -: 2]              = {1'b0, bus.cmd_op};
        hdr[LII_DW-3 -: 8]              = bus.cmd_len;
        hdr[LII_DW-11 -: 3]             = bus.cmd_size;
        hdr[LII_DW-14 -: AXI_AW]        = bus.cmd_addr;
        hdr[LII_DW-14-AXI_AW -: TAG_W]  = bus.cmd_tag;
    end

    always_comb begin
        bus.cmd_ready      = (state_q == StIdle);
        // A write may load its first beat while the header is leaving, so the stream has no bubble.
        bus.wr_ready       = ((state_q == StSendHdr && op_q) || state_q == StSendW) &&
                             (beat_rem_q != 9'd0) && (!req_valid_q || bus.lii_req_ready);
        bus.rd_valid       = 1'b0;
        bus.rd_data        = '0;
        bus.rd_last        = 1'b0;
        bus.lii_resp_ready = 1'b0;
        if (state_q == StWaitR) begin
            bus.rd_valid       = bus.lii_resp_valid;
            bus.rd_data        = bus.lii_resp_data[AXI_DW-1:0];
            bus.rd_last        = bus.lii_resp_last;
            bus.lii_resp_ready = bus.rd_ready;
        end else if (state_q == StWaitB) begin
            bus.lii_resp_ready = !done_valid_q;
        end
    end

    assign wr_hs   = bus.wr_valid && bus.wr_ready;
    assign resp_hs = bus.lii_resp_valid && bus.lii_resp_ready;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        len_d        = len_q;
        beat_rem_d   = beat_rem_q;
        beat_cnt_d   = beat_cnt_q;
        req_data_d   = req_data_q;
        req_keep_d   = req_keep_q;
        req_strb_d   = req_strb_q;
        req_last_d   = req_last_q;
        req_valid_d  = req_valid_q;
        done_valid_d = done_valid_q;
        done_resp_d  = done_resp_q;
        err_d        = err_q;

        if (req_valid_q && bus.lii_req_ready) req_valid_d = 1'b0;
        if (done_valid_q && bus.wr_done_ready) done_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    op_d        = bus.cmd_op;
                    len_d       = bus.cmd_len;
                    beat_rem_d  = {1'b0, bus.cmd_len} + 9'd1;
                    beat_cnt_d  = 9'd0;
                    req_data_d  = hdr;
                    req_keep_d  = '1;
                    req_strb_d  = '0;
                    req_last_d  = !bus.cmd_op;
                    req_valid_d = 1'b1;
                    state_d     = StSendHdr;
                end
            end
            StSendHdr: begin
                if (bus.lii_req_ready) state_d = op_q ? StSendW : StWaitR;
            end
            StSendW: begin
                if (req_valid_q && bus.lii_req_ready && beat_rem_q == 9'd0) state_d = StWaitB;
            end
            StWaitR: begin
                if (resp_hs) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (bus.lii_resp_last != (beat_cnt_q == {1'b0, len_q})) err_d = 1'b1;
                    if (bus.lii_resp_last) state_d = StIdle;
                end
            end
            StWaitB: begin
                if (resp_hs) begin
                    done_valid_d = 1'b1;
                    done_resp_d  = bus.lii_resp_data[1:0];
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_hs) begin
            req_data_d  = LII_DW'(bus.wr_data);
            req_strb_d  = LB'(bus.wr_strb);
            req_keep_d  = LB'({SW{1'b1}});
            req_last_d  = (beat_rem_q == 9'd1);
            req_valid_d = 1'b1;
            beat_rem_d  = beat_rem_q - 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            op_q         <= 1'b0;
            len_q        <= '0;
            beat_rem_q   <= '0;
            beat_cnt_q   <= '0;
            req_data_q   <= '0;
            req_keep_q   <= '0;
            req_strb_q   <= '0;
            req_last_q   <= 1'b0;
            req_valid_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_resp_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            len_q        <= len_d;
            beat_rem_q   <= beat_rem_d;
            beat_cnt_q   <= beat_cnt_d;
            req_data_q   <= req_data_d;
            req_keep_q   <= req_keep_d;
            req_strb_q   <= req_strb_d;
            req_last_q   <= req_last_d;
            req_valid_q  <= req_valid_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
            err_q        <= err_d;
        end
    end

    assign bus.lii_req_data  = req_data_q;
    assign bus.lii_req_keep  = req_keep_q;
    assign bus.lii_req_strb  = req_strb_q;
    assign bus.lii_req_last  = req_last_q;
    assign bus.lii_req_valid = req_valid_q;
    assign bus.wr_done_valid = done_valid_q;
    assign bus.wr_done_resp  = done_resp_q;
    assign busy              = (state_q != StIdle);
    assign err_len           = err_q;

    // Response keep/strb and upper data bits carry nothing this block needs.
    assign unused_resp = ^{bus.lii_resp_keep, bus.lii_resp_strb, bus.lii_resp_data};
endmodule

// File: tb/tb_lii_mem_initiator.sv
// Randomized bench for lii_mem_initiator: drives commands, write beats and LII responses,
// and scores request flits, read beats, write status and err_len against a reference model.
module tb_lii_mem_initiator;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 128;
    localparam int unsigned LW = 256;
    localparam int unsigned TW = 8;
    localparam int unsigned SB = DW / 8;
    localparam int unsigned LB = LW / 8;
    localparam int Limit = 3000;

    typedef struct packed {
        logic [LW-1:0] data;
        logic [LB-1:0] keep;
        logic [LB-1:0] strb;
        logic          last;
    } flit_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic busy, err_len;

    lii_mem_initiator_if #(.AXI_AW(AW), .AXI_DW(DW), .LII_DW(LW), .TAG_W(TW)) bus ();

    lii_mem_initiator #(.AXI_AW(AW), .AXI_DW(DW), .LII_DW(LW), .TAG_W(TW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .busy    (busy),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit err_model = 1'b0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_lw();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r = (r << 32) | LW'($urandom);
        return r;
    endfunction

    // Header fields placed MSB-first by plain shifts of each field's offset from the top.
    function automatic flit_t hdr_flit(input bit op, input logic [7:0] len, input logic [2:0] size,
                                       input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        flit_t f;
        f.data = (LW'(op) << (LW - 2)) | (LW'(len) << (LW - 10)) | (LW'(size) << (LW - 13)) |
                 (LW'(addr) << (LW - 13 - AW)) | (LW'(tag) << (LW - 13 - AW - TW));
        f.keep = '1;
        f.strb = '0;
        f.last = !op;
        return f;
    endfunction

    function automatic flit_t data_flit(input logic [DW-1:0] d, input logic [SB-1:0] s, input bit last);
        flit_t f;
        f.data = LW'(d);
        f.strb = LB'(s);
        f.keep = (LB'(1) << SB) - LB'(1);
        f.last = last;
        return f;
    endfunction

    // mode: 0 = random lii_req_ready, 1 = held high (no write gaps), 2 = toggling every cycle
    task automatic run_txn(input bit op, input int len, input int nresp, input logic [AW-1:0] addr,
                           input logic [2:0] size, input logic [TW-1:0] tag, input int mode);
        flit_t exp_req[$];
        flit_t got_req[$];
        beat_t exp_rd[$];
        beat_t got_rd[$];
        logic [DW-1:0] wdat[$];
        logic [SB-1:0] wstb[$];
        logic [1:0] bresp;
        int first_t;
        int last_t;

        bresp = 2'($urandom);
        first_t = -1;
        last_t = -1;
        exp_req.push_back(hdr_flit(op, 8'(len), size, addr, tag));
        if (op) begin
            for (int i = 0; i <= len; i++) begin
                wdat.push_back(DW'(rand_lw()));
                wstb.push_back(SB'($urandom));
                exp_req.push_back(data_flit(wdat[i], wstb[i], i == len));
            end
        end else begin
            for (int i = 0; i < nresp; i++) begin
                beat_t b;
                b.data = DW'(rand_lw());
                b.last = (i == nresp - 1);
                exp_rd.push_back(b);
            end
            if (nresp != len + 1) err_model = 1'b1;
        end

        fork
            begin : p_cmd
                int t = 0;
                @(negedge clk);
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = op;
                bus.cmd_len   = 8'(len);
                bus.cmd_addr  = addr;
                bus.cmd_size  = size;
                bus.cmd_tag   = tag;
                #1;
                while (!bus.cmd_ready && t < Limit) begin
                    @(negedge clk);
                    #1;
                    t++;
                end
                if (t >= Limit) check_eq("cmd_timeout", bus.cmd_ready, 1);
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
            end
            begin : p_wr
                if (op) begin
                    for (int i = 0; i <= len; i++) begin
                        int t = 0;
                        @(negedge clk);
                        bus.wr_valid = 1'b0;
                        if (mode != 1) while ($urandom_range(3) == 0) @(negedge clk);
                        bus.wr_valid = 1'b1;
                        bus.wr_data  = wdat[i];
                        bus.wr_strb  = wstb[i];
                        #1;
                        while (!bus.wr_ready && t < Limit) begin
                            @(negedge clk);
                            #1;
                            t++;
                        end
                        if (t >= Limit) begin
                            check_eq("wr_timeout", bus.wr_ready, 1);
                            break;
                        end
                        @(posedge clk);
                        #1;
                    end
                    bus.wr_valid = 1'b0;
                end
            end
            begin : p_req
                int t = 0;
                bit rdy = 1'b0;
                bit stalled = 1'b0;
                flit_t prev;
                while (got_req.size() < exp_req.size() && t < Limit) begin
                    flit_t cur;
                    @(negedge clk);
                    rdy = (mode == 1) ? 1'b1 : (mode == 2) ? !rdy : 1'($urandom);
                    bus.lii_req_ready = rdy;
                    #1;
                    t++;
                    cur.data = bus.lii_req_data;
                    cur.keep = bus.lii_req_keep;
                    cur.strb = bus.lii_req_strb;
                    cur.last = bus.lii_req_last;
                    if (stalled) begin
                        check_eq("req_hold_valid", bus.lii_req_valid, 1);
                        check_eq("req_hold_data", cur.data, prev.data);
                        check_eq("req_hold_ctl", {cur.keep, cur.strb, cur.last},
                                 {prev.keep, prev.strb, prev.last});
                    end
                    if (bus.lii_req_valid && bus.lii_req_ready) begin
                        got_req.push_back(cur);
                        if (first_t < 0) first_t = t;
                        last_t = t;
                    end
                    stalled = bus.lii_req_valid && !bus.lii_req_ready;
                    if (stalled) check_eq("wr_ready_while_full", bus.wr_ready, 0);
                    prev = cur;
                end
                if (t >= Limit) check_eq("req_timeout", got_req.size(), exp_req.size());
                @(posedge clk);
                #1;
                bus.lii_req_ready = 1'b0;
            end
            begin : p_resp
                int nb;
                nb = op ? 1 : nresp;
                for (int i = 0; i < nb; i++) begin
                    int t = 0;
                    logic [LW-1:0] d;
                    @(negedge clk);
                    bus.lii_resp_valid = 1'b0;
                    while ($urandom_range(3) == 0) @(negedge clk);
                    d = rand_lw();
                    if (op) d[1:0] = bresp;
                    else d[DW-1:0] = exp_rd[i].data;
                    bus.lii_resp_valid = 1'b1;
                    bus.lii_resp_data  = d;
                    bus.lii_resp_keep  = LB'(rand_lw());
                    bus.lii_resp_strb  = LB'(rand_lw());
                    bus.lii_resp_last  = op ? 1'b1 : (i == nb - 1);
                    #1;
                    while (!bus.lii_resp_ready && t < Limit) begin
                        @(negedge clk);
                        #1;
                        t++;
                    end
                    if (t >= Limit) begin
                        check_eq("resp_timeout", bus.lii_resp_ready, 1);
                        break;
                    end
                    @(posedge clk);
                    #1;
                end
                bus.lii_resp_valid = 1'b0;
            end
            begin : p_rd
                if (!op) begin
                    int t = 0;
                    int hold = 0;
                    bit done = 1'b0;
                    while (!done && t < Limit) begin
                        @(negedge clk);
                        if (hold > 0) begin
                            bus.rd_ready = 1'b0;
                            hold--;
                        end else begin
                            bus.rd_ready = ($urandom_range(2) != 0);
                        end
                        #1;
                        t++;
                        if (!bus.rd_ready) check_eq("resp_ready_stall", bus.lii_resp_ready, 0);
                        if (bus.rd_valid && bus.rd_ready) begin
                            beat_t b;
                            b.data = bus.rd_data;
                            b.last = bus.rd_last;
                            got_rd.push_back(b);
                            done = b.last;
                            if (got_rd.size() == 1) hold = 5;
                        end
                    end
                    if (!done) check_eq("rd_timeout", done, 1);
                    @(posedge clk);
                    #1;
                    bus.rd_ready = 1'b0;
                end
            end
            begin : p_done
                if (op) begin
                    int t = 0;
                    bit done = 1'b0;
                    bit pend = 1'b0;
                    while (!done && t < Limit) begin
                        @(negedge clk);
                        bus.wr_done_ready = ($urandom_range(2) == 0);
                        #1;
                        t++;
                        if (pend) check_eq("wr_done_hold", bus.wr_done_valid, 1);
                        check_eq("rd_valid_in_write", bus.rd_valid, 0);
                        if (bus.wr_done_valid && bus.wr_done_ready) begin
                            check_eq("wr_done_resp", bus.wr_done_resp, bresp);
                            done = 1'b1;
                        end
                        pend = bus.wr_done_valid && !bus.wr_done_ready;
                    end
                    if (!done) check_eq("wr_done_timeout", done, 1);
                    @(posedge clk);
                    #1;
                    bus.wr_done_ready = 1'b0;
                end
            end
        join

        check_eq("req_count", got_req.size(), exp_req.size());
        for (int i = 0; i < exp_req.size() && i < got_req.size(); i++) begin
            check_eq("req_data", got_req[i].data, exp_req[i].data);
            check_eq("req_ctl", {got_req[i].keep, got_req[i].strb, got_req[i].last},
                     {exp_req[i].keep, exp_req[i].strb, exp_req[i].last});
        end
        if (mode == 1 && got_req.size() > 0) check_eq("req_b2b", last_t - first_t, exp_req.size() - 1);
        if (!op) begin
            check_eq("rd_count", got_rd.size(), exp_rd.size());
            for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
                check_eq("rd_beat", {got_rd[i].data, got_rd[i].last}, {exp_rd[i].data, exp_rd[i].last});
        end
        @(negedge clk);
        check_eq("busy_after", busy, 0);
        check_eq("err_len", err_len, err_model);
        if (op) begin
            bus.wr_valid = 1'b1;
            #1;
            check_eq("wr_extra_beat", bus.wr_ready, 0);
            @(negedge clk);
            bus.wr_valid = 1'b0;
        end
    endtask

    task automatic reset_mid_write();
        int acc = 0;
        int t = 0;
        @(negedge clk);
        bus.cmd_valid     = 1'b1;
        bus.cmd_op        = 1'b1;
        bus.cmd_len       = 8'd3;
        bus.cmd_addr      = AW'(48'h2000);
        bus.cmd_size      = 3'd4;
        bus.cmd_tag       = 8'h11;
        bus.lii_req_ready = 1'b1;
        #1;
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        while (acc < 2 && t < Limit) begin
            @(negedge clk);
            bus.wr_valid = 1'b1;
            bus.wr_data  = DW'(rand_lw());
            bus.wr_strb  = '1;
            #1;
            t++;
            if (bus.wr_ready) begin
                @(posedge clk);
                #1;
                acc++;
            end
        end
        if (t >= Limit) check_eq("rst_wr_timeout", acc, 2);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        check_eq("rst_busy_before", busy, 1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        bus.lii_req_ready = 1'b0;
        err_model = 1'b0;
        check_eq("rst_req_valid", bus.lii_req_valid, 0);
        check_eq("rst_cmd_ready_after", bus.cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err_len", err_len, 0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;     bus.cmd_op = 1'b0;       bus.cmd_addr = '0;
        bus.cmd_len = '0;         bus.cmd_size = '0;       bus.cmd_tag = '0;
        bus.wr_data = '0;         bus.wr_strb = '0;        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;      bus.wr_done_ready = 1'b0;
        bus.lii_req_ready = 1'b0;
        bus.lii_resp_data = '0;   bus.lii_resp_keep = '0;  bus.lii_resp_strb = '0;
        bus.lii_resp_last = 1'b0; bus.lii_resp_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_req_valid", bus.lii_req_valid, 0);
        check_eq("reset_req_data", bus.lii_req_data, 0);
        check_eq("reset_cmd_ready", bus.cmd_ready, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_err_len", err_len, 0);
        check_eq("reset_wr_done", {bus.wr_done_valid, bus.wr_done_resp}, 0);
        check_eq("reset_resp_ready", bus.lii_resp_ready, 0);
        rstn = 1'b1;

        run_txn(1'b0, 3, 4, AW'(48'h1000), 3'd4, 8'h5A, 0);
        run_txn(1'b1, 1, 0, AW'(48'h1040), 3'd4, 8'h21, 1);
        run_txn(1'b1, 7, 0, AW'(48'h2000), 3'd4, 8'h33, 2);
        for (int n = 0; n < 30; n++) begin
            bit op;
            int len;
            op = 1'($urandom);
            len = (n == 7) ? 40 : $urandom_range(0, 12);
            run_txn(op, len, len + 1, AW'({$urandom, $urandom}), 3'($urandom), TW'($urandom),
                    $urandom_range(0, 2));
        end

        // Short, long and then correct read: err_len must latch and stay set.
        run_txn(1'b0, 3, 2, AW'(48'h3000), 3'd4, 8'h44, 0);
        run_txn(1'b0, 2, 5, AW'(48'h3100), 3'd4, 8'h45, 0);
        run_txn(1'b0, 3, 4, AW'(48'h3200), 3'd4, 8'h46, 0);

        reset_mid_write();
        run_txn(1'b0, 2, 3, AW'(48'h4000), 3'd3, 8'h77, 0);
        run_txn(1'b1, 0, 0, AW'(48'h4100), 3'd3, 8'h78, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
